reg_wr_arbiter: RTL and testbench

- Owns the register file's single write port and shares it between NREQ write-back requesters (ALU, load unit, debug/CSR) using round-robin arbitration with a valid/ready handshake.
- Contains a clear sequencer that zeroes x1..x31 after reset and again on command, so hardware reset leaves the register file in a defined state.
- Outputs drive the register file's wr_en/wr_addr/wr_data directly and are registered, giving 1-cycle latency.

---
 rtl/reg_wr_arbiter_if.sv | 33 +++
 rtl/reg_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_reg_wr_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wr_arbiter_if.sv
// Bus between the write-back requesters and the register-file write port.
//   req_valid/req_addr/req_data : packed per-requester write requests
//   req_ready                   : one-hot accept, combinational
//   clr_start/clr_busy/clr_done : clear-sweep command and status
//   wr_en/wr_addr/wr_data       : registered register-file write port
//   grant_id                    : requester behind the current wr_* values
interface reg_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NREQ       = 3,
    parameter int GW         = 2
);
    logic [NREQ-1:0]            req_valid;
    logic [5*NREQ-1:0]          req_addr;
    logic [DATA_WIDTH*NREQ-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       clr_start;
    logic                       clr_busy;
    logic                       clr_done;
    logic                       wr_en;
    logic [4:0]                 wr_addr;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic [GW-1:0]              grant_id;

    modport master (
        output req_valid, req_addr, req_data, clr_start,
        input  req_ready, clr_busy, clr_done, wr_en, wr_addr, wr_data, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_start,
        output req_ready, clr_busy, clr_done, wr_en, wr_addr, wr_data, grant_id
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Register-file write-port owner: round-robin arbitration among NREQ
// write-back requesters plus a clear sweep that zeroes x1..x31 after reset
// and on clr_start.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : reg_wr_arbiter_if slave (requests, clear control, write port)
//
// state   | meaning
// --------+---------------------------------------------------
// CLEAR   | sweeping zeros into x1..x31, one address per cycle
// IDLE    | arbitrating write-back requests
module reg_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NREQ       = 3,
    parameter int GW         = 2
) (
    input  logic             clk,
    input  logic             reset,
    reg_wr_arbiter_if.slave  bus
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [4:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [GW-1:0]         grant_id_q, grant_id_d;
    logic                  clr_done_q, clr_done_d;

    logic                  found;
    logic [GW-1:0]         grant_idx;
    logic [NREQ-1:0]       req_ready;
    logic [4:0]            sel_addr;

    // Priority search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = GW'(idx);
            end
        end
    end

    assign sel_addr = bus.req_addr[int'(grant_idx)*5 +: 5];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        clr_done_d = 1'b0;
        req_ready  = '0;
        case (state_q)
            ST_CLEAR: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = cnt_q;
                wr_data_d  = '0;
                grant_id_d = '0;
                if (cnt_q == 5'd31) begin
                    clr_done_d = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = 5'd1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                if (bus.clr_start) begin
                    // Clear wins over any pending request this cycle.
                    state_d = ST_CLEAR;
                end else if (found) begin
                    req_ready[grant_idx] = 1'b1;
                    wr_addr_d  = sel_addr;
                    wr_data_d  = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_d = grant_idx;
                    // x0 writes are accepted but never reach the register file.
                    wr_en_d    = (sel_addr != 5'd0);
                    if (int'(grant_idx) == NREQ - 1) rr_ptr_d = '0;
                    else                             rr_ptr_d = grant_idx + GW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= 5'd1;
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.clr_busy  = (state_q == ST_CLEAR);
    assign bus.clr_done  = clr_done_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.grant_id  = grant_id_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed plus randomized bench for reg_wr_arbiter against a
// transaction-level reference model (sweep countdown + round-robin search).
module tb_reg_wr_arbiter;
    localparam int DW   = 32;
    localparam int NREQ = 3;
    localparam int GW   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_wr_arbiter_if #(.DATA_WIDTH(DW), .NREQ(NREQ), .GW(GW)) bus ();
    reg_wr_arbiter #(.DATA_WIDTH(DW), .NREQ(NREQ), .GW(GW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // stimulus
    logic [NREQ-1:0] valid;
    logic [4:0]      addr [NREQ];
    logic [DW-1:0]   data [NREQ];
    logic            clr;
    logic [NREQ-1:0] last_ready;

    always_comb begin
        bus.req_valid = valid;
        bus.clr_start = clr;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*5 +: 5]   = addr[i];
            bus.req_data[i*DW +: DW] = data[i];
        end
    end

    // reference model
    int            sweep_left;
    int            rr;
    logic          m_en;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data;
    logic [GW-1:0] m_gid;
    logic          m_done;
    int            done_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sweep_left = 31;
        rr         = 0;
        m_en       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_gid      = '0;
        m_done     = 1'b0;
    endtask

    // Called just after a rising edge; checks combinational outputs mid-cycle,
    // then the registered outputs after the next edge.
    task automatic cycle();
        logic [NREQ-1:0] e_ready;
        int g;
        #4;
        e_ready = '0;
        m_done  = 1'b0;
        check("clr_busy", 64'(bus.clr_busy), 64'(sweep_left > 0));
        if (sweep_left > 0) begin
            m_en   = 1'b1;
            m_addr = 5'(32 - sweep_left);
            m_data = '0;
            m_gid  = '0;
            m_done = (sweep_left == 1);
            sweep_left--;
        end else if (clr) begin
            m_en       = 1'b0;
            sweep_left = 31;
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
            if (g >= 0) begin
                e_ready[g] = 1'b1;
                m_en   = (addr[g] != 5'd0);
                m_addr = addr[g];
                m_data = data[g];
                m_gid  = GW'(g);
                rr     = (g + 1) % NREQ;
            end else begin
                m_en = 1'b0;
            end
        end
        check("req_ready", 64'(bus.req_ready), 64'(e_ready));
        last_ready = e_ready;
        @(posedge clk);
        #1;
        check("wr_en",    64'(bus.wr_en),    64'(m_en));
        check("wr_addr",  64'(bus.wr_addr),  64'(m_addr));
        check("wr_data",  64'(bus.wr_data),  64'(m_data));
        check("grant_id", 64'(bus.grant_id), 64'(m_gid));
        check("clr_done", 64'(bus.clr_done), 64'(m_done));
        if (bus.clr_done) done_cnt++;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [DW-1:0] d);
        valid[i] = v;
        addr[i]  = a;
        data[i]  = d;
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (!valid[i] || last_ready[i]) begin
                valid[i] = ($urandom_range(0, 3) != 0);
                addr[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                data[i]  = $urandom;
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        clr        = 1'b0;
        last_ready = '0;
        done_cnt   = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), DW'(i));
        model_reset();

        // reset values, with requests pending
        @(posedge clk); #1;
        check("rst_wr_en",     64'(bus.wr_en),     64'(0));
        check("rst_wr_addr",   64'(bus.wr_addr),   64'(0));
        check("rst_wr_data",   64'(bus.wr_data),   64'(0));
        check("rst_grant_id",  64'(bus.grant_id),  64'(0));
        check("rst_clr_done",  64'(bus.clr_done),  64'(0));
        check("rst_clr_busy",  64'(bus.clr_busy),  64'(1));
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));

        // initial sweep with no requests
        valid = '0;
        reset = 1'b1;
        repeat (31) cycle();
        check("sweep1_done_cnt", 64'(done_cnt), 64'(1));

        // all three requesters valid continuously
        set_req(0, 1'b1, 5'd5, 32'hA);
        set_req(1, 1'b1, 5'd6, 32'hB);
        set_req(2, 1'b1, 5'd7, 32'hC);
        repeat (6) cycle();

        // requester 2 alone
        valid = '0;
        set_req(2, 1'b1, 5'd9, 32'h1234);
        repeat (4) cycle();

        // x0 write from requester 0 is accepted and dropped, then requester 1
        valid = '0;
        set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        set_req(1, 1'b1, 5'd3, 32'h5555);
        cycle();
        check("x0_drop_en", 64'(bus.wr_en), 64'(0));
        valid[0] = 1'b0;
        cycle();
        check("after_x0_grant", 64'(bus.grant_id), 64'(1));

        // requester 0 once more to leave rr_ptr at 1, then clr_start with 1,2 valid
        valid = '0;
        set_req(0, 1'b1, 5'd4, 32'h44);
        cycle();
        valid = '0;
        set_req(1, 1'b1, 5'd11, 32'h111);
        set_req(2, 1'b1, 5'd12, 32'h222);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        done_cnt = 0;
        repeat (31) cycle();
        check("sweep2_done_cnt", 64'(done_cnt), 64'(1));
        cycle();
        check("post_clear_first", 64'(bus.grant_id), 64'(1));

        // randomized traffic with occasional clear requests
        valid = '0;
        for (int n = 0; n < 400; n++) begin
            rand_reqs();
            clr = ($urandom_range(0, 39) == 0);
            cycle();
        end
        clr = 1'b0;
        valid = '0;
        repeat (32) cycle();

        // reset in the middle of a sweep
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int n = 0; n < 40 && m_addr != 5'd10; n++) cycle();
        check("pre_rst_addr", 64'(bus.wr_addr), 64'(10));
        #2;
        reset = 1'b0;
        #1;
        check("async_wr_en",   64'(bus.wr_en),    64'(0));
        check("async_wr_addr", 64'(bus.wr_addr),  64'(0));
        check("async_busy",    64'(bus.clr_busy), 64'(1));
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        done_cnt = 0;
        repeat (31) cycle();
        check("sweep3_done_cnt", 64'(done_cnt), 64'(1));
        set_req(0, 1'b1, 5'd20, 32'hDEAD);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
